// File: rtl/pc_fetch_seq.sv
// PC register and instruction-fetch sequencer.
// Owns the fetch PC, keeps at most one instruction-memory request in flight,
// and redirects fetch from exception vector, eret/EPC, or a resolved branch
// target. Fetched words are presented to the IF/ID register with their PC.
//
// Handshake: imem_req is a one-cycle strobe qualified by imem_addr; the
// memory answers with a one-cycle imem_ready pulse (imem_rdata valid with it)
// at least one cycle later. imem_ready is only meaningful while a request is
// outstanding; it is ignored in every other state.
module pc_fetch_seq #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic        if_adel,
   output logic [1:0]  fsm_state
);

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] pc_nxt;
   logic        pend_v;
   logic        pend_v_nxt;
   logic [31:0] pend_pc;
   logic [31:0] pend_pc_nxt;
   logic        word_load;
   logic        adel_load;
   logic        redir_ev;
   logic [31:0] target;
   logic [31:0] pc_plus4;

   // Redirect source priority: exception, then eret, then branch/jump.
   always_comb begin
      redir_ev = exc_req | eret | redirect;
      target   = redirect_pc;
      if (exc_req) begin
         target = EXC_VEC;
      end else if (eret) begin
         target = epc;
      end
   end

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;
   assign fsm_state = state;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_BOOT;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state, request strobe and next values of PC / pending redirect.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      pend_v_nxt  = pend_v;
      pend_pc_nxt = pend_pc;
      imem_req    = 1'b0;
      word_load   = 1'b0;
      adel_load   = 1'b0;
      unique case (state)
         S_BOOT: begin
            state_nxt = S_REQ;
         end
         S_REQ: begin
            if (redir_ev) begin
               pc_nxt = target;
            end else if (!stall) begin
               if (pc[1:0] != 2'b00) begin
                  // Misaligned fetch: report it, never touch memory.
                  adel_load = 1'b1;
               end else begin
                  imem_req  = 1'b1;
                  state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (imem_ready) begin
               state_nxt  = S_REQ;
               pend_v_nxt = 1'b0;
               if (redir_ev) begin
                  pc_nxt = target;
               end else if (pend_v) begin
                  pc_nxt = pend_pc;
               end else begin
                  word_load = 1'b1;
                  pc_nxt    = pc_plus4;
               end
            end else if (redir_ev) begin
               // Remember the newest redirect; the in-flight word is wrong-path.
               pend_v_nxt  = 1'b1;
               pend_pc_nxt = target;
            end
         end
         default: begin
            state_nxt = S_BOOT;
         end
      endcase
   end

   // PC and pending-redirect registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc      <= RESET_PC;
         pend_v  <= 1'b0;
         pend_pc <= 32'd0;
      end else begin
         pc      <= pc_nxt;
         pend_v  <= pend_v_nxt;
         pend_pc <= pend_pc_nxt;
      end
   end

   // IF output register: load a word or an address error, hold under stall,
   // otherwise drop to invalid (this also flushes on a redirect).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_valid <= 1'b0;
         if_instr <= 32'd0;
         if_pc    <= 32'd0;
         if_pc4   <= 32'd4;
         if_adel  <= 1'b0;
      end else if (word_load) begin
         if_valid <= 1'b1;
         if_instr <= imem_rdata;
         if_pc    <= pc;
         if_pc4   <= pc_plus4;
         if_adel  <= 1'b0;
      end else if (adel_load) begin
         if_valid <= 1'b1;
         if_instr <= 32'd0;
         if_pc    <= pc;
         if_pc4   <= pc_plus4;
         if_adel  <= 1'b1;
      end else if (!stall) begin
         if_valid <= 1'b0;
         if_adel  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed scenarios followed by random traffic.
// A transaction-level reference model predicts fetch addresses and the words
// that must reach the IF stage; a monitor compares the IF outputs.
module tb_pc_fetch_seq;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_VEC  = 32'h0000_4180;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic        eret;
   logic [31:0] epc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic        if_adel;
   logic [1:0]  fsm_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   pc_fetch_seq #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .exc_req(exc_req), .eret(eret), .epc(epc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .pc(pc), .if_valid(if_valid), .if_instr(if_instr),
      .if_pc(if_pc), .if_pc4(if_pc4), .if_adel(if_adel), .fsm_state(fsm_state)
   );

   // ---------------- scoreboard state ----------------
   typedef struct {
      int          due;
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
   endtask

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   // ---------------- reference model ----------------
   // Architectural view: the next address to fetch, whether one fetch is in
   // flight, and whether a redirect has made that in-flight word useless.
   logic [31:0] m_next;
   logic [31:0] m_inflight;
   logic        m_busy = 1'b0;
   logic        m_squash = 1'b0;
   logic        m_boot = 1'b1;
   int          words_acc = 0;
   int          resp_due = -10;
   logic [31:0] resp_addr = 32'd0;
   int          min_lat = 1;
   int          max_lat = 1;

   logic        m_ev;
   logic [31:0] m_tgt;
   logic        m_exp_req;
   logic        m_exp_adel;

   always @(negedge clk) begin
      if (reset) begin
         m_next   = RESET_PC;
         m_busy   = 1'b0;
         m_squash = 1'b0;
         m_boot   = 1'b1;
         exp_q.delete();
      end else if (m_boot) begin
         m_boot = 1'b0;
         chk("boot_no_req", 32'(imem_req), 32'd0);
      end else begin
         m_ev  = exc_req | eret | redirect;
         m_tgt = exc_req ? EXC_VEC : (eret ? epc : redirect_pc);
         m_exp_req  = !m_busy && !m_ev && !stall && (m_next[1:0] == 2'b00);
         m_exp_adel = !m_busy && !m_ev && !stall && (m_next[1:0] != 2'b00);
         if (imem_req || m_exp_req) chk("imem_req", 32'(imem_req), 32'(m_exp_req));
         if (imem_req && m_exp_req) begin
            chk("imem_addr", imem_addr, m_next);
            chk("pc_at_req", pc, m_next);
         end
         if (m_busy && imem_ready) begin
            if (!m_squash && !m_ev) begin
               exp_q.push_back('{cyc + 1, m_inflight, word_of(m_inflight), 1'b0});
               words_acc++;
            end
            m_busy = 1'b0;
         end else if (m_busy && m_ev) begin
            m_squash = 1'b1;
         end
         if (m_ev) m_next = m_tgt;
         if (m_exp_req) begin
            m_inflight = m_next;
            resp_addr  = m_next;
            m_busy     = 1'b1;
            m_squash   = 1'b0;
            m_next     = m_next + 32'd4;
            resp_due   = cyc + int'($urandom_range(max_lat, min_lat));
         end
         if (m_exp_adel) exp_q.push_back('{cyc + 1, m_next, 32'd0, 1'b1});
      end
   end

   // ---------------- monitor ----------------
   logic        prev_reset = 1'b1;
   logic        prev_stall = 1'b0;
   logic        h_valid;
   logic [31:0] h_pc;
   logic [31:0] h_instr;
   exp_t        e;

   always @(negedge clk) begin
      if (reset) begin
         chk("rst_imem_req", 32'(imem_req), 32'd0);
         chk("rst_pc", pc, RESET_PC);
         chk("rst_if_valid", 32'(if_valid), 32'd0);
         chk("rst_if_adel", 32'(if_adel), 32'd0);
         chk("rst_if_instr", if_instr, 32'd0);
         chk("rst_if_pc", if_pc, 32'd0);
         chk("rst_if_pc4", if_pc4, 32'd4);
      end else if (!prev_reset) begin
         if (!prev_stall) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
               e = exp_q.pop_front();
               chk("if_valid_word", 32'(if_valid), 32'd1);
               chk("if_pc", if_pc, e.pc);
               chk("if_instr", if_instr, e.instr);
               chk("if_adel", 32'(if_adel), 32'(e.adel));
               if (!e.adel) chk("if_pc4", if_pc4, e.pc + 32'd4);
            end else begin
               chk("if_valid_idle", 32'(if_valid), 32'd0);
            end
         end else begin
            chk("hold_if_valid", 32'(if_valid), 32'(h_valid));
            chk("hold_if_pc", if_pc, h_pc);
            chk("hold_if_instr", if_instr, h_instr);
         end
      end
      prev_reset = reset;
      prev_stall = stall;
      h_valid    = if_valid;
      h_pc       = if_pc;
      h_instr    = if_instr;
   end

   // ---------------- driver tasks ----------------
   // Advance one cycle; inputs default to quiet and the memory responder
   // answers the outstanding fetch when its latency expires.
   task automatic tick();
      @(posedge clk);
      #1;
      stall       = 1'b0;
      redirect    = 1'b0;
      exc_req     = 1'b0;
      eret        = 1'b0;
      redirect_pc = $urandom;
      epc         = $urandom;
      imem_ready  = (cyc == resp_due);
      imem_rdata  = imem_ready ? word_of(resp_addr) : $urandom;
   endtask

   task automatic do_reset(input int n);
      tick();
      reset = 1'b1;
      repeat (n) tick();
      reset = 1'b0;
   endtask

   // Return in a cycle where no fetch is in flight (DUT ready to issue).
   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!m_busy && !m_boot && !reset) return;
      end
      timeout_fail("wait_idle");
   endtask

   task automatic wait_words(input int n, input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (words_acc >= n) return;
      end
      timeout_fail("wait_words");
   endtask

   function automatic logic [31:0] rand_target();
      int k;
      k = int'($urandom_range(0, 99));
      if (k < 6) return 32'h0000_3000 + ($urandom_range(0, 255) << 2) + $urandom_range(1, 3);
      if (k < 10) return 32'hFFFF_FFF0 + ($urandom_range(0, 3) << 2);
      return 32'h0000_3000 + ($urandom_range(0, 1023) << 2);
   endfunction

   // ---------------- stimulus ----------------
   int r;

   initial begin
      reset       = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'd0;
      exc_req     = 1'b0;
      eret        = 1'b0;
      epc         = 32'd0;
      imem_ready  = 1'b0;
      imem_rdata  = 32'd0;
      repeat (2) tick();
      reset = 1'b0;

      // Zero-stall streaming, 1-cycle memory: 3000, 3004, 3008.
      wait_words(words_acc + 3, 40);

      // Stall for 4 cycles right after the word at 3004 lands.
      do_reset(2);
      wait_words(words_acc + 2, 40);
      stall = 1'b1;
      repeat (3) begin
         tick();
         stall = 1'b1;
      end

      // Redirect while waiting; memory answers 3 cycles after the request.
      min_lat = 3;
      max_lat = 3;
      wait_idle(50);
      tick();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_3100;
      wait_idle(50);
      wait_words(words_acc + 1, 50);

      // Exception beats redirect in the same cycle, then eret to 3008.
      min_lat = 1;
      max_lat = 1;
      wait_idle(50);
      exc_req     = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_5000;
      wait_idle(50);
      eret = 1'b1;
      epc  = 32'h0000_3008;
      wait_words(words_acc + 1, 50);

      // Misaligned target: address error, no memory access, then exception.
      wait_idle(50);
      redirect    = 1'b1;
      redirect_pc = 32'h0000_3102;
      repeat (4) tick();
      exc_req = 1'b1;
      wait_words(words_acc + 1, 50);

      // PC wrap-around from FFFF_FFFC to 0.
      wait_idle(50);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      wait_words(words_acc + 2, 50);

      // Reset during an outstanding fetch; the response lands inside reset.
      min_lat = 3;
      max_lat = 3;
      wait_idle(50);
      tick();
      do_reset(4);
      min_lat = 1;
      max_lat = 1;
      wait_words(words_acc + 1, 50);

      // Random traffic.
      min_lat = 1;
      max_lat = 4;
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 999) < 3) begin
            do_reset(int'($urandom_range(1, 3)));
         end else begin
            stall = !m_busy && ($urandom_range(0, 99) < 15);
            r = int'($urandom_range(0, 99));
            if (r < 8) begin
               redirect    = 1'b1;
               redirect_pc = rand_target();
            end else if (r < 11) begin
               exc_req     = 1'b1;
               redirect    = 1'($urandom_range(0, 1));
               eret        = 1'($urandom_range(0, 1));
            end else if (r < 14) begin
               eret        = 1'b1;
               epc         = rand_target();
               redirect    = 1'($urandom_range(0, 1));
            end
         end
      end
      repeat (10) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
